// File: rtl/cpu_pkg.sv
// cpu_pkg: shared arbiter state type, requester indices and RAM word width
package cpu_pkg;
  typedef enum logic {ARB, BURST} ArbState;
  localparam int REQ_FETCH = 0;
  localparam int REQ_DATA = 1;
  localparam int REQ_DMA = 2;
  localparam int RAM_WORD_W = 32;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first valid requester after last
module rr_pick (
  input  logic [2:0] valid,
  input  logic [1:0] last,
  output logic [2:0] grant,
  output logic [1:0] idx
);
  // scan from the farthest candidate back to the nearest so the nearest valid one wins
  always_comb begin
    grant = '0;
    idx = '0;
    for (int k = 3; k >= 1; k--)
      if (valid[(int'(last) + k) % 3]) begin
        idx = 2'((int'(last) + k) % 3);
        grant = 3'(3'b001 << idx);
      end
  end
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter with locked bursts for a shared 32-bit RAM; RAM_ARBITER_DMA_EN enables requester 2
module ram_arbiter
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int BURST_MAX = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [2:0]            i_req_valid,
  input  logic [2:0]            i_req_we,
  input  logic [2:0]            i_req_lock,
  input  logic [11:0]           i_req_be,
  input  logic [3*ADDR_W-1:0]   i_req_addr,
  input  logic [95:0]           i_req_wdata,
  output logic [2:0]            o_req_ready,
  output logic [2:0]            o_rsp_valid,
  output logic [RAM_WORD_W-1:0] o_rsp_rdata,
  output logic                  o_ram_en,
  output logic [3:0]            o_ram_we,
  output logic [ADDR_W-1:0]     o_ram_addr,
  output logic [RAM_WORD_W-1:0] o_ram_wdata,
  input  logic [RAM_WORD_W-1:0] i_ram_rdata
);
`ifdef RAM_ARBITER_DMA_EN
  localparam logic [2:0] REQ_MASK = 3'b111;
  localparam logic [1:0] RR_RST = 2'(REQ_DMA);
`else
  localparam logic [2:0] REQ_MASK = 3'b011;
  localparam logic [1:0] RR_RST = 2'(REQ_DATA);
`endif
  ArbState state, state_n;
  logic [1:0] rr_last, rr_last_n, owner, owner_n, pick_idx, widx;
  logic [2:0] valid_m, pick_grant, grant, rsp_q;
  logic [3:0] cnt, cnt_n, w_be;
  logic xfer, w_we, w_lock;
  logic [ADDR_W-1:0] w_addr;
  logic [RAM_WORD_W-1:0] w_wdata;

  assign valid_m = i_req_valid & REQ_MASK;

  rr_pick u_pick (
    .valid(valid_m),
    .last(rr_last),
    .grant(pick_grant),
    .idx(pick_idx)
  );

  assign widx = state == BURST ? owner : pick_idx;
  assign grant = state == BURST ? (valid_m[owner] ? 3'(3'b001 << owner) : 3'b000) : pick_grant;
  assign xfer = |grant && !i_rst;
  assign w_be = i_req_be[4*widx +: 4];
  assign w_addr = i_req_addr[ADDR_W*widx +: ADDR_W];
  assign w_wdata = i_req_wdata[RAM_WORD_W*widx +: RAM_WORD_W];
  assign w_we = i_req_we[widx];
  assign w_lock = i_req_lock[widx];

  assign o_req_ready = xfer ? grant : 3'b000;
  assign o_ram_en = xfer;
  assign o_ram_we = xfer ? w_be & {4{w_we}} : 4'b0000;
  assign o_ram_addr = xfer ? w_addr : '0;
  assign o_ram_wdata = xfer ? w_wdata : '0;
  assign o_rsp_valid = rsp_q;
  assign o_rsp_rdata = |rsp_q ? i_ram_rdata : '0;

  // next state: enter a burst on a locked beat, leave it on unlock, full count or a dropped valid
  always_comb begin
    state_n = state;
    owner_n = owner;
    rr_last_n = rr_last;
    cnt_n = cnt;
    if (state == ARB) begin
      if (xfer && w_lock && BURST_MAX > 1) begin
        state_n = BURST;
        owner_n = widx;
        cnt_n = 4'd1;
      end else if (xfer) rr_last_n = widx;
    end else if (!xfer || !w_lock || cnt + 4'd1 == 4'(BURST_MAX)) begin
      state_n = ARB;
      rr_last_n = owner;
      cnt_n = '0;
    end else cnt_n = cnt + 4'd1;
  end

  // state registers; a read beat marks its requester for a response next cycle
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state <= ARB;
      owner <= '0;
      rr_last <= RR_RST;
      cnt <= '0;
      rsp_q <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      rr_last <= rr_last_n;
      cnt <= cnt_n;
      rsp_q <= xfer && !w_we ? grant : 3'b000;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed scoreboard bench for ram_arbiter; follows RAM_ARBITER_DMA_EN
module tb_ram_arbiter;
  localparam int AW = 14;
`ifdef RAM_ARBITER_DMA_EN
  localparam bit DMA = 1'b1;
`else
  localparam bit DMA = 1'b0;
`endif
  typedef struct {logic [2:0] oh; logic [31:0] d;} rsp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] v, we, lk;
  logic [3:0] be[3];
  logic [AW-1:0] ad[3];
  logic [31:0] wd[3];
  logic [2:0] o_req_ready, o_rsp_valid;
  logic [31:0] o_rsp_rdata, o_ram_wdata, ram_rdata;
  logic o_ram_en;
  logic [3:0] o_ram_we;
  logic [AW-1:0] o_ram_addr;
  logic [31:0] mem[16384];
  logic [31:0] shadow[16384];
  rsp_t q[$];
  int checks = 0;
  int errors = 0;
  int lr;
  logic [2:0] loh;

  ram_arbiter #(.ADDR_W(AW), .BURST_MAX(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(v), .i_req_we(we), .i_req_lock(lk),
    .i_req_be({be[2], be[1], be[0]}),
    .i_req_addr({ad[2], ad[1], ad[0]}),
    .i_req_wdata({wd[2], wd[1], wd[0]}),
    .o_req_ready(o_req_ready), .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata),
    .o_ram_en(o_ram_en), .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr),
    .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (o_ram_en) begin
      for (int b = 0; b < 4; b++)
        if (o_ram_we[b]) mem[o_ram_addr][8*b +: 8] <= o_ram_wdata[8*b +: 8];
      if (o_ram_we == 4'b0000) ram_rdata <= mem[o_ram_addr];
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set(input int n, input bit val, input bit w, input bit l,
                     input logic [3:0] b, input logic [AW-1:0] a, input logic [31:0] d);
    v[n] = val; we[n] = w; lk[n] = l; be[n] = b; ad[n] = a; wd[n] = d;
  endtask

  task automatic cyc(input string tag, input logic [2:0] er);
    int w;
    rsp_t e;
    logic [3:0] xwe;
    #3;
    w = er[2] ? 2 : er[1] ? 1 : 0;
    xwe = er != 3'b000 ? be[w] & {4{we[w]}} : 4'b0000;
    chk({tag, ".ready"}, 32'(o_req_ready), 32'(er));
    chk({tag, ".ram_en"}, 32'(o_ram_en), 32'(er != 3'b000));
    chk({tag, ".ram_we"}, 32'(o_ram_we), 32'(xwe));
    chk({tag, ".ram_addr"}, 32'(o_ram_addr), er != 3'b000 ? 32'(ad[w]) : 32'd0);
    chk({tag, ".ram_wdata"}, o_ram_wdata, er != 3'b000 ? wd[w] : 32'd0);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".rsp_valid"}, 32'(o_rsp_valid), 32'(e.oh));
      chk({tag, ".rsp_rdata"}, o_rsp_rdata, e.d);
    end else begin
      chk({tag, ".rsp_idle"}, 32'(o_rsp_valid), 32'd0);
      chk({tag, ".rdata_idle"}, o_rsp_rdata, 32'd0);
    end
    if (er != 3'b000) begin
      if (!we[w]) q.push_back('{er, shadow[ad[w]]});
      else for (int b = 0; b < 4; b++)
        if (be[w][b]) shadow[ad[w]][8*b +: 8] = wd[w][8*b +: 8];
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = 32'(i) * 32'h9E3779B1;
      shadow[i] = 32'(i) * 32'h9E3779B1;
    end
    ram_rdata = '0;
    for (int n = 0; n < 3; n++) set(n, 1'b1, 1'b1, 1'b1, 4'hF, AW'(n + 1), 32'hDEAD0000 + 32'(n));
    #9;
    chk("rst.ready", 32'(o_req_ready), 32'd0);
    chk("rst.ram_en", 32'(o_ram_en), 32'd0);
    chk("rst.ram_we", 32'(o_ram_we), 32'd0);
    chk("rst.ram_addr", 32'(o_ram_addr), 32'd0);
    chk("rst.ram_wdata", o_ram_wdata, 32'd0);
    chk("rst.rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst.rsp_rdata", o_rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = '0;
    set(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0010, 32'd0);
    cyc("single_read", 3'b001);
    v = '0;
    cyc("single_rsp", 3'b000);
    do_reset();
    set(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0100, 32'd0);
    set(1, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0110, 32'd0);
    set(2, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0120, 32'd0);
    for (int i = 0; i < 6; i++)
      cyc("rr_all", DMA ? 3'(3'b001 << (i % 3)) : 3'(3'b001 << (i % 2)));
    v = '0;
    cyc("rr_drain", 3'b000);
    set(1, 1'b1, 1'b1, 1'b1, 4'hF, 14'h0020, 32'h10000001);
    cyc("burst_b1", 3'b010);
    set(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0030, 32'd0);
    for (int b = 2; b <= 4; b++) begin
      ad[1] = AW'(32 + b - 1);
      wd[1] = 32'h10000000 + 32'(b);
      cyc("burst_b", 3'b010);
    end
    ad[1] = 14'h0024;
    wd[1] = 32'h10000005;
    cyc("burst_gap", 3'b001);
    v[0] = 1'b0;
    cyc("burst_b5", 3'b010);
    lk[1] = 1'b0;
    ad[1] = 14'h0025;
    wd[1] = 32'h10000006;
    cyc("burst_b6", 3'b010);
    v = '0;
    set(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0023, 32'd0);
    cyc("burst_rb", 3'b001);
    v = '0;
    cyc("burst_rb_rsp", 3'b000);
    lr = DMA ? 2 : 1;
    loh = 3'(3'b001 << lr);
    set(lr, 1'b1, 1'b0, 1'b1, 4'hF, 14'h0040, 32'd0);
    cyc("drop_b1", loh);
    set(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0041, 32'd0);
    ad[lr] = 14'h0042;
    cyc("drop_b2", loh);
    v[lr] = 1'b0;
    cyc("drop_gap", 3'b000);
    v[lr] = 1'b1;
    lk[lr] = 1'b0;
    cyc("drop_next", 3'b001);
    v[0] = 1'b0;
    cyc("drop_back", loh);
    v = '0;
    cyc("drop_rsp", 3'b000);
    set(0, 1'b1, 1'b1, 1'b0, 4'b0101, 14'h0050, 32'hAABBCCDD);
    cyc("be_write", 3'b001);
    v = '0;
    cyc("be_norsp", 3'b000);
    set(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0050, 32'd0);
    cyc("be_rb", 3'b001);
    v = '0;
    cyc("be_rb_rsp", 3'b000);
    set(0, 1'b1, 1'b0, 1'b0, 4'hF, 14'h0060, 32'd0);
    cyc("rst_read", 3'b001);
    rst = 1'b1;
    #3;
    chk("rst_mid.rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_mid.rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_mid.ready", 32'(o_req_ready), 32'd0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    v = '0;
    cyc("rst_after1", 3'b000);
    cyc("rst_after2", 3'b000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: word-address width of the shared 32-bit RAM (16384 words).
REQ-002 Parameter BURST_MAX, default 4: maximum beats one locked grant may hold; legal range 1..15.
REQ-003 Port i_clk  input  1: single clock; every register updates on its rising edge.
REQ-004 Port i_rst  input  1: reset, asynchronous, active-high.
REQ-005 Port i_req_valid  input  3: per requester, request present; index 0 = CPU fetch, 1 = CPU data, 2 = DMA.
REQ-006 Port i_req_we  input  3: per requester, 1 = write, 0 = read.
REQ-007 Port i_req_lock  input  3: per requester, keep the grant for the next beat.
REQ-008 Port i_req_be  input  12: per-requester byte enables, 4 bits each; requester n occupies [4n+3:4n].
REQ-009 Port i_req_addr  input  3*ADDR_W: per-requester word address, packed in the same order.
REQ-010 Port i_req_wdata  input  96: per-requester write data, 32 bits each.
REQ-011 Port o_req_ready  output  3: one-hot accept; a beat transfers when valid and ready are both 1.
REQ-012 Port o_rsp_valid  output  3: one-hot, read data available for that requester.
REQ-013 Port o_rsp_rdata  output  32: read data, valid only while o_rsp_valid is nonzero.
REQ-014 Port o_ram_en  output  1: RAM access strobe.
REQ-015 Port o_ram_we  output  4: RAM byte write enables.
REQ-016 Port o_ram_addr  output  ADDR_W: RAM word address.
REQ-017 Port o_ram_wdata  output  32: RAM write data.
REQ-018 Port i_ram_rdata  input  32: synchronous RAM read data, one cycle after o_ram_en with o_ram_we == 0.

Function
REQ-019 FSM states: ARB and BURST. In ARB the arbiter picks the first valid requester in round-robin order, starting after the pointer rr_last.
REQ-020 Grant, o_req_ready and the RAM drive are combinational within the cycle.
  - o_ram_en = 1 exactly when a beat transfers.
  - o_ram_we = be & {4{we}} of the winner.
  - o_ram_addr and o_ram_wdata come from the winner.
  - When no beat transfers, the RAM outputs are held at 0.
REQ-021 o_req_ready has at most one bit set, and only for a valid requester.
REQ-022 Read response: an accepted read beat sets o_rsp_valid for its requester exactly 1 cycle later, and o_rsp_rdata = i_ram_rdata in that cycle.
  - Accepted writes produce no response.
  - Throughput is 1 beat per cycle.
REQ-023 ARB to BURST: taken when the accepted beat has lock = 1 and BURST_MAX > 1. The owner is latched and the beat counter is set to 1.
REQ-024 In BURST:
  - Only the owner may be ready, and a valid beat from the owner is accepted that cycle; the beat counter increments per beat.
  - Return to ARB when the accepted beat has lock = 0, or when the counter reaches BURST_MAX.
  - Return to ARB when the owner's valid is 0 for one cycle; this is a lock drop and no beat transfers.
REQ-025 rr_last is set to the granted index when a single-beat grant completes in ARB, and to the owner when BURST exits. Requesters that are not valid are skipped.
REQ-026 Simultaneous requests from all three with rr_last = 0 are granted in the order 1, 2, 0, 1, …; no requester waits more than 2 grants.
REQ-027 A lock asserted when BURST_MAX = 1 is ignored; the FSM stays in ARB.

Reset
REQ-028 While i_rst = 1, all of the following hold:
  - the FSM is in ARB, rr_last = 2, and the beat counter = 0;
  - o_req_ready = 0, o_rsp_valid = 0, o_rsp_rdata = 0;
  - o_ram_en = 0, o_ram_we = 0, o_ram_addr = 0, o_ram_wdata = 0.
REQ-029 A reset asserted mid-burst or with a read in flight discards that state; no response is issued after reset is released.

Configuration
REQ-030 Macro RAM_ARBITER_DMA_EN defined: requester 2 takes part in arbitration as specified above.
REQ-031 Macro RAM_ARBITER_DMA_EN undefined:
  - requester 2 inputs are ignored;
  - o_req_ready[2] and o_rsp_valid[2] are tied to 0;
  - round-robin runs between 0 and 1 only, and the reset value of rr_last is 1.

Structure
REQ-032 Shared package cpu_pkg holds:
  - ArbState enum {ARB, BURST};
  - requester index constants REQ_FETCH = 0, REQ_DATA = 1, REQ_DMA = 2;
  - RAM_WORD_W = 32.
REQ-033 Sub-module rr_pick is a combinational round-robin picker: inputs are a valid mask and rr_last; outputs are a one-hot grant and an index.

Verification
REQ-034 Reset, then valid = 3'b001, read, addr 0x0010 → ready = 001 in cycle 0, o_ram_en = 1 with addr 0x0010, and in cycle 1 o_rsp_valid = 001 with rdata equal to the RAM contents.
REQ-035 Valid = 3'b111 held for 6 cycles after reset → grant order 0, 1, 2, 0, 1, 2.
REQ-036 Requester 1 issues a locked write burst of 6 beats with BURST_MAX = 4, while requester 0 is valid → requester 1 gets 4 consecutive beats, requester 0 gets the 5th cycle, and requester 1 resumes after that.
REQ-037 Requester 2 is locked, drops valid for one cycle mid-burst, while requester 0 is valid → requester 0 is granted on the cycle after the drop.
REQ-038 Write be = 4'b0101 with data 0xAABBCCDD → o_ram_we = 0101 and no o_rsp_valid is issued.
REQ-039 i_rst pulsed the cycle after a read is accepted → o_rsp_valid stays 0; build without RAM_ARBITER_DMA_EN with valid = 111 → only bits 0 and 1 are ever ready.
